// File: rtl/aes_round_key_server_if.sv
// Round-key server bus: schedule load stream, indexed read request and
// the registered round-key responses. The decrypt line exists only when
// AES_KEY_REVERSE_EN is defined.
interface aes_round_key_server_if #(
    parameter int ADDR_W = 5
);
    logic                 key_clear;
    logic                 key_wr_en;
    logic [31:0]          key_wr_data;
    logic                 key_rd_en;
    logic [ADDR_W-1:0]    round_key_addr;
`ifdef AES_KEY_REVERSE_EN
    logic                 decrypt;
`endif
    logic [127:0]         round_key_input;
    logic [127:0]         round_key_0;
    logic                 key_rd_valid;
    logic                 key_ready;
    logic                 addr_err;

    // Key-expansion writer / round engine side
    modport master (
`ifdef AES_KEY_REVERSE_EN
        output decrypt,
`endif
        output key_clear, key_wr_en, key_wr_data, key_rd_en, round_key_addr,
        input  round_key_input, round_key_0, key_rd_valid, key_ready, addr_err
    );

    // Key server side
    modport slave (
`ifdef AES_KEY_REVERSE_EN
        input  decrypt,
`endif
        input  key_clear, key_wr_en, key_wr_data, key_rd_en, round_key_addr,
        output round_key_input, round_key_0, key_rd_valid, key_ready, addr_err
    );
endinterface

// File: rtl/aes_round_key_server.sv
// aes_round_key_server: stores the expanded AES key schedule (loaded as a
// stream of 32-bit words, first word of each key in the MSBs) and serves
// registered round keys by round index with one-cycle latency.
// Optional feature: define AES_KEY_REVERSE_EN to add the decrypt input,
// which mirrors the round index (NUM_ROUNDS - addr) and shows the last
// round key on round_key_0.
module aes_round_key_server #(
    parameter int NUM_ROUNDS = 10,
    parameter int ADDR_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_round_key_server_if.slave bus
);
    localparam int NUM_KEYS  = NUM_ROUNDS + 1;
    localparam int NUM_WORDS = 4 * NUM_KEYS;
    localparam int WCNT_W    = $clog2(NUM_WORDS);
    localparam int KIDX_W    = WCNT_W - 2;
    localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        ST_LOADING = 1'b0,
        ST_READY   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [127:0]        mem_q [NUM_KEYS];
    logic [127:0]        mem_d [NUM_KEYS];
    logic [127:0]        rk_in_q, rk_in_d;
    logic [127:0]        rk0_q, rk0_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;

    logic                dec_s;
    logic [ADDR_W-1:0]   ea_s;
    logic [KIDX_W-1:0]   rd_idx_s;
    logic [KIDX_W-1:0]   rk0_idx_s;
    logic [KIDX_W-1:0]   wr_idx_s;

`ifdef AES_KEY_REVERSE_EN
    assign dec_s = bus.decrypt;
`else
    assign dec_s = 1'b0;
`endif

    // Effective index: mirrored in decrypt mode; bounds are checked on the raw address
    assign ea_s      = dec_s ? (MAX_ADDR - bus.round_key_addr) : bus.round_key_addr;
    assign rd_idx_s  = KIDX_W'(ea_s);
    assign rk0_idx_s = dec_s ? KIDX_W'(NUM_ROUNDS) : {KIDX_W{1'b0}};
    assign wr_idx_s  = wcnt_q[WCNT_W-1:2];

    // Next-state: clear beats load/read; load only while not ready; read bounds check
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        mem_d      = mem_q;
        rk_in_d    = rk_in_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        if (bus.key_clear) begin
            state_d = ST_LOADING;
            wcnt_d  = {WCNT_W{1'b0}};
        end else begin
            if (bus.key_wr_en && (state_q == ST_LOADING)) begin
                case (wcnt_q[1:0])
                    2'd0:    mem_d[wr_idx_s][127:96] = bus.key_wr_data;
                    2'd1:    mem_d[wr_idx_s][95:64]  = bus.key_wr_data;
                    2'd2:    mem_d[wr_idx_s][63:32]  = bus.key_wr_data;
                    2'd3:    mem_d[wr_idx_s][31:0]   = bus.key_wr_data;
                    default: mem_d[wr_idx_s][127:96] = bus.key_wr_data;
                endcase
                if (wcnt_q == LAST_WCNT) begin
                    wcnt_d  = {WCNT_W{1'b0}};
                    state_d = ST_READY;
                end else begin
                    wcnt_d = wcnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                wcnt_d = wcnt_q;
            end
            if (bus.key_rd_en) begin
                if ((state_q == ST_READY) && (bus.round_key_addr <= MAX_ADDR)) begin
                    rk_in_d    = mem_q[rd_idx_s];
                    rd_valid_d = 1'b1;
                end else begin
                    addr_err_d = 1'b1;
                end
            end else begin
                rd_valid_d = 1'b0;
            end
        end
        // Uses next-cycle storage so the whitening key is valid with key_ready
        if (state_d == ST_READY) begin
            rk0_d = mem_d[rk0_idx_s];
        end else begin
            rk0_d = 128'd0;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOADING;
            wcnt_q     <= {WCNT_W{1'b0}};
            rk_in_q    <= 128'd0;
            rk0_q      <= 128'd0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rk_in_q    <= rk_in_d;
            rk0_q      <= rk0_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Key storage; contents survive reset and clear, validity is tracked by state
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.round_key_input = rk_in_q;
    assign bus.round_key_0     = rk0_q;
    assign bus.key_rd_valid    = rd_valid_q;
    assign bus.addr_err        = addr_err_q;
    assign bus.key_ready       = (state_q == ST_READY);

endmodule

// File: tb/tb_aes_round_key_server.sv
// Scoreboard bench for aes_round_key_server: stimulus pushes the expected
// response of every read it issues; a negedge monitor pops and compares on
// each key_rd_valid / addr_err pulse.
module tb_aes_round_key_server;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct {
        logic         is_err;
        logic [127:0] data;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [127:0] last_data;

    aes_round_key_server_if #(.ADDR_W(5)) bus ();

    aes_round_key_server #(.NUM_ROUNDS(10), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] kdata(input logic [31:0] base, input int k);
        logic [31:0] w0;
        w0 = base + 32'(4 * k);
        return {w0, w0 + 32'd1, w0 + 32'd2, w0 + 32'd3};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [127:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    // Drive one read for a cycle (rd_en left high for back-to-back streams)
    task automatic rd(input int addr, input logic ok, input logic [127:0] data);
        bus.key_rd_en      = 1'b1;
        bus.round_key_addr = 5'(addr);
        if (ok) begin
            last_data = data;
        end
        push_exp(!ok, last_data);
        tick();
    endtask

    task automatic idle();
        bus.key_rd_en  = 1'b0;
        bus.key_wr_en  = 1'b0;
        bus.key_clear  = 1'b0;
        tick();
    endtask

    // Full 44-word load; key_ready must stay low until after the last write
    task automatic load(input logic [31:0] base, input logic rd_last);
        for (int i = 0; i < 44; i++) begin
            bus.key_wr_en   = 1'b1;
            bus.key_wr_data = base + 32'(i);
            if (rd_last && (i == 43)) begin
                bus.key_rd_en      = 1'b1;
                bus.round_key_addr = 5'd0;
                push_exp(1'b1, last_data);
            end
            chk("ready_low_during_load", 128'(bus.key_ready), 128'd0);
            tick();
        end
        bus.key_wr_en = 1'b0;
        bus.key_rd_en = 1'b0;
        chk("ready_after_load", 128'(bus.key_ready), 128'd1);
        chk("rk0_after_load", bus.round_key_0, kdata(base, 0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rk_in"}, bus.round_key_input, 128'd0);
        chk({tag, "_rk0"}, bus.round_key_0, 128'd0);
        chk({tag, "_valid"}, 128'(bus.key_rd_valid), 128'd0);
        chk({tag, "_ready"}, 128'(bus.key_ready), 128'd0);
        chk({tag, "_err"}, 128'(bus.addr_err), 128'd0);
    endtask

    // Response monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (bus.key_rd_valid || bus.addr_err) begin
            if (sb_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_resp: valid=%0b err=%0b data=%h", bus.key_rd_valid,
                         bus.addr_err, bus.round_key_input);
            end else begin
                mon_e = sb_q.pop_front();
                total = total + 1;
                if ((bus.addr_err !== mon_e.is_err) || (bus.key_rd_valid !== !mon_e.is_err) ||
                    (bus.round_key_input !== mon_e.data)) begin
                    bad = bad + 1;
                    $display("FAIL read_resp: valid=%0b err=%0b data=%h expected err=%0b data=%h",
                             bus.key_rd_valid, bus.addr_err, bus.round_key_input,
                             mon_e.is_err, mon_e.data);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        last_data          = 128'd0;
        rst                = 1'b1;
        bus.key_clear      = 1'b0;
        bus.key_wr_en      = 1'b0;
        bus.key_wr_data    = 32'd0;
        bus.key_rd_en      = 1'b0;
        bus.round_key_addr = 5'd0;
`ifdef AES_KEY_REVERSE_EN
        bus.decrypt        = 1'b0;
`endif
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Load with a read in the final write cycle (rejected)
        load(32'h0000_0000, 1'b1);

        // Back-to-back reads of every round key
        for (int k = 0; k <= 10; k++) begin
            rd(k, 1'b1, kdata(32'h0000_0000, k));
        end
        // Out-of-range reads keep the last key
        rd(11, 1'b0, 128'd0);
        rd(31, 1'b0, 128'd0);
        idle();

        // Write after load is ignored
        bus.key_wr_en   = 1'b1;
        bus.key_wr_data = 32'hDEAD_BEEF;
        tick();
        bus.key_wr_en = 1'b0;
        rd(0, 1'b1, kdata(32'h0000_0000, 0));
        idle();
        chk("rk0_after_extra_write", bus.round_key_0, kdata(32'h0000_0000, 0));

        // Clear, partial load, read rejected while loading
        bus.key_clear = 1'b1;
        tick();
        bus.key_clear = 1'b0;
        chk("ready_after_clear", 128'(bus.key_ready), 128'd0);
        chk("rk0_after_clear", bus.round_key_0, 128'd0);
        for (int i = 0; i < 20; i++) begin
            bus.key_wr_en   = 1'b1;
            bus.key_wr_data = 32'h0000_0100 + 32'(i);
            tick();
        end
        bus.key_wr_en = 1'b0;
        rd(0, 1'b0, 128'd0);
        idle();

        // Clear with same-cycle write and read: write dropped, no error pulse
        bus.key_clear      = 1'b1;
        bus.key_wr_en      = 1'b1;
        bus.key_wr_data    = 32'hBAD0_0000;
        bus.key_rd_en      = 1'b1;
        bus.round_key_addr = 5'd0;
        tick();
        bus.key_clear = 1'b0;
        bus.key_wr_en = 1'b0;
        bus.key_rd_en = 1'b0;
        chk("ready_after_clear_combo", 128'(bus.key_ready), 128'd0);
        load(32'h0000_0100, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            rd(k, 1'b1, kdata(32'h0000_0100, k));
        end
        idle();

        // Reset in the middle of a read stream
        rd(0, 1'b1, kdata(32'h0000_0100, 0));
        rd(1, 1'b1, kdata(32'h0000_0100, 1));
        rd(2, 1'b1, kdata(32'h0000_0100, 2));
        bus.round_key_addr = 5'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.key_rd_en = 1'b0;
        chk_zero("mid_rst");
        last_data = 128'd0;
        rd(0, 1'b0, 128'd0);
        rd(10, 1'b0, 128'd0);
        idle();
        load(32'h0000_0200, 1'b0);
        rd(5, 1'b1, kdata(32'h0000_0200, 5));
        idle();

`ifdef AES_KEY_REVERSE_EN
        // Reverse-order addressing, decrypt sampled per read
        bus.decrypt = 1'b1;
        rd(0, 1'b1, kdata(32'h0000_0200, 10));
        chk("rk0_decrypt", bus.round_key_0, kdata(32'h0000_0200, 10));
        rd(10, 1'b1, kdata(32'h0000_0200, 0));
        rd(11, 1'b0, 128'd0);
        bus.decrypt = 1'b0;
        rd(0, 1'b1, kdata(32'h0000_0200, 0));
        idle();
        chk("rk0_encrypt", bus.round_key_0, kdata(32'h0000_0200, 0));
`endif

        idle();
        idle();
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
